lab7_1soc_key_pio: RTL and testbench
====================================

// Module: lab7_1soc_key_pio
// PURPOSE
// - Avalon-MM input PIO: opposite direction to the output PIO driving usb_rst; samples external in_port
//   (keys/switches/USB IRQ lines) for the NIOS II to read over s1.
// - Synchronizes inputs, latches per-bit edges in an edge-capture register, raises masked level IRQ.
// PARAMETERS
// - WIDTH        8  number of input bits (1..32)
// - SYNC_STAGES  2  synchronizer flops on in_port (>=2)
// - EDGE_TYPE    0  0=rising, 1=falling, 2=any edge
// PORTS
// - clk        in   1      system clock
// - reset      in   1      synchronous reset, active-high
// - address    in   2      register select
// - chipselect in   1      slave select
// - write_n    in   1      active-low write strobe
// - writedata  in   32     write data
// - readdata   out  32     read data, 1-cycle read latency
// - in_port    in   WIDTH  asynchronous external inputs
// - irq        out  1      level interrupt to CPU
// BEHAVIOUR
// - Register map (word addr): 0 DATA (RO, synchronized in_port); 1 reserved (reads 0, writes ignored);
//   2 IRQMASK (RW, WIDTH bits); 3 EDGECAPTURE (RW1C or clear-all, see CONFIGURATION).
// - Write = chipselect & ~write_n; only writedata[WIDTH-1:0] used; writes to addr 0/1 ignored.
// - readdata registered every clk from current address (chipselect not required); bits [31:WIDTH] = 0.
// - Sync chain s[0..SYNC_STAGES-1], then d_prev <= s[last]. edge = s&~d_prev / ~s&d_prev / s^d_prev per EDGE_TYPE.
// - Latency: in_port change -> EDGECAPTURE bit set and irq high at clk edge SYNC_STAGES+1; -> readdata
//   (addr 0) at SYNC_STAGES+1.
// - EDGECAPTURE bit sets on edge, holds until cleared; set and clear in same cycle -> set wins (no lost edge).
// - irq = |(EDGECAPTURE & IRQMASK), combinational from registers; mask write takes effect next cycle.
// - Reset: sync chain, d_prev, IRQMASK, EDGECAPTURE, readdata all 0; irq 0.
// - Arming: 3-bit hold-off counter loads SYNC_STAGES+1 on reset; edge detection disabled while nonzero,
//   so inputs held high across reset do not register a spurious rising edge. Counter stops at 0.
// - Reset asserted mid-operation: all state clears on that clk edge regardless of pending writes.
// CONFIGURATION
// - LAB7_EDGE_BIT_CLEAR_EN defined: write to addr 3 clears only bits where writedata[i]=1 (RW1C).
// - Undefined: any write to addr 3 clears all EDGECAPTURE bits, writedata ignored.
// - Set-wins rule applies in both modes.
// TESTING (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0)
// - Reset with in_port=8'hFF, release, wait 10 cycles -> EDGECAPTURE reads 0, irq=0, DATA reads 32'h000000FF.
// - in_port 8'h00->8'h05 -> EDGECAPTURE=8'h05 at edge 3; IRQMASK=0 -> irq stays 0; write IRQMASK=8'h04 -> irq=1 next cycle.
// - With EDGECAPTURE=8'h05: write addr3 8'h01 -> BIT_CLEAR_EN: reads 8'h04, irq stays 1; else reads 8'h00, irq=0.
// - Rising edge on bit0 same cycle as clear write 8'hFF to addr 3 -> bit0 remains 1.
// - Falling edge 8'h01->8'h00 with EDGE_TYPE=0 -> no capture; repeat with EDGE_TYPE=2 -> bit0 captured.
// - Read addr 1 -> 0; write addr 0 32'hDEAD -> DATA unchanged; reset during pending IRQ -> irq 0 same edge.

Source files
------------

// File: rtl/lab7_1soc_key_pio.sv
// Avalon-MM input PIO: synchronizes in_port, latches per-bit edges, raises a masked level IRQ.
// Optional build macro LAB7_EDGE_BIT_CLEAR_EN: EDGECAPTURE writes clear only the 1-bits (RW1C).
module lab7_1soc_key_pio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam int         HOLD_INIT_I = (SYNC_STAGES + 1 > 7) ? 7 : SYNC_STAGES + 1;
  localparam logic [2:0] HOLD_INIT   = 3'(HOLD_INIT_I);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [2:0]       hold_q, hold_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             unused_writedata;

  assign sync_last        = sync_q[SYNC_STAGES-1];
  assign wr_en            = chipselect & ~write_n;
  assign unused_writedata = ^writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = sync_last & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = ~sync_last & prev_q;
    end else begin : g_any
      assign edge_raw = sync_last ^ prev_q;
    end
  endgenerate

  // Edges are ignored until the chain has refilled after reset.
  assign edge_det = (hold_q == 3'd0) ? edge_raw : '0;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
`ifdef LAB7_EDGE_BIT_CLEAR_EN
    clr_bits = writedata[WIDTH-1:0];
`else
    clr_bits = '1;
`endif
  end

  always_comb begin
    prev_d = sync_last;
    hold_d = (hold_q == 3'd0) ? 3'd0 : hold_q - 3'd1;

    mask_d = mask_q;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end

    // Clear first, then OR in new edges so a coincident edge is never lost.
    cap_d = cap_q;
    if (wr_en && address == 2'd3) begin
      cap_d = cap_q & ~clr_bits;
    end
    cap_d = cap_d | edge_det;

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = sync_last;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      hold_q     <= HOLD_INIT;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      hold_q     <= hold_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_lab7_1soc_key_pio.sv
// Directed bench for lab7_1soc_key_pio: a rising-edge instance and an any-edge instance share the bus.
module tb_lab7_1soc_key_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic [1:0]  addr_b;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_b;
  logic [7:0]  in_port;
  logic        irq;
  logic        irq_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab7_1soc_key_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  lab7_1soc_key_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(addr_b), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .in_port(in_port), .irq(irq_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; addr_b = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    $display("wr addr=%0d data=%08h irq=%0b", a, d, irq);
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
    $display("rd addr=%0d data=%08h irq=%0b", a, readdata, irq);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_port = 8'hFF; address = 2'd0; addr_b = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    ticks(3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%08h exp=00000000", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    reset = 1'b0;
    ticks(10);
    addr_b = 2'd3;
    bus_read(2'd3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL arm_cap got=%08h exp=00000000", readdata); end
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL arm_cap_any got=%08h exp=00000000", readdata_b); end
    total++; if (irq !== 1'b0 || irq_b !== 1'b0) begin bad++; $display("FAIL arm_irq got=%0b/%0b exp=0/0", irq, irq_b); end
    addr_b = 2'd0;
    bus_read(2'd0);
    total++; if (readdata !== 32'h000000FF) begin bad++; $display("FAIL arm_data got=%08h exp=000000FF", readdata); end
  endtask

  task automatic test_edge_capture();
    in_port = 8'h00;
    ticks(6);
    address = 2'd3; addr_b = 2'd0;
    tick();
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL fall_ignored got=%08h exp=00000000", readdata); end
    in_port = 8'h05;
    ticks(2);
    total++; if (readdata_b !== 32'h0) begin bad++; $display("FAIL data_early got=%08h exp=00000000", readdata_b); end
    tick();
    total++; if (readdata_b !== 32'h05) begin bad++; $display("FAIL data_latency got=%08h exp=00000005", readdata_b); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL cap_early got=%08h exp=00000000", readdata); end
    tick();
    total++; if (readdata !== 32'h05) begin bad++; $display("FAIL cap_latency got=%08h exp=00000005", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%0b exp=0", irq); end
    bus_write(2'd2, 32'h04);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_unmasked got=%0b exp=1", irq); end
    bus_read(2'd2);
    total++; if (readdata !== 32'h04) begin bad++; $display("FAIL mask_read got=%08h exp=00000004", readdata); end
  endtask

  task automatic test_clear();
    logic [31:0] exp_cap;
    logic        exp_irq;
`ifdef LAB7_EDGE_BIT_CLEAR_EN
    exp_cap = 32'h04; exp_irq = 1'b1;
`else
    exp_cap = 32'h00; exp_irq = 1'b0;
`endif
    bus_write(2'd3, 32'h01);
    total++; if (irq !== exp_irq) begin bad++; $display("FAIL clear_irq got=%0b exp=%0b", irq, exp_irq); end
    bus_read(2'd3);
    total++; if (readdata !== exp_cap) begin bad++; $display("FAIL clear_cap got=%08h exp=%08h", readdata, exp_cap); end
  endtask

  task automatic test_set_wins();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h04;
    ticks(5);
    bus_read(2'd3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL setwins_pre got=%08h exp=00000000", readdata); end
    in_port = 8'h05;
    ticks(2);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3);
    total++; if (readdata !== 32'h01) begin bad++; $display("FAIL setwins_cap got=%08h exp=00000001", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL setwins_irq got=%0b exp=0", irq); end
  endtask

  task automatic test_falling();
    in_port = 8'h01;
    ticks(5);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    ticks(5);
    address = 2'd3; addr_b = 2'd3;
    tick();
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL fall_rise_only got=%08h exp=00000000", readdata); end
    total++; if (readdata_b !== 32'h01) begin bad++; $display("FAIL fall_any_edge got=%08h exp=00000001", readdata_b); end
  endtask

  task automatic test_reserved();
    in_port = 8'hA5;
    ticks(5);
    bus_read(2'd1);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reserved_read got=%08h exp=00000000", readdata); end
    bus_write(2'd0, 32'h0000DEAD);
    addr_b = 2'd0;
    bus_read(2'd0);
    total++; if (readdata !== 32'h000000A5) begin bad++; $display("FAIL data_ro got=%08h exp=000000A5", readdata); end
    bus_write(2'd1, 32'hFF);
    bus_read(2'd2);
    total++; if (readdata !== 32'h04) begin bad++; $display("FAIL reserved_write got=%08h exp=00000004", readdata); end
    bus_read(2'd3);
    total++; if (readdata !== 32'hA5) begin bad++; $display("FAIL cap_multi got=%08h exp=000000A5", readdata); end
  endtask

  task automatic test_reset_mid();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pending_irq got=%0b exp=1", irq); end
    reset = 1'b1; address = 2'd2; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%0b exp=0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL midreset_rd got=%08h exp=00000000", readdata); end
    chipselect = 1'b0; write_n = 1'b1; writedata = '0; reset = 1'b0;
    ticks(10);
    bus_read(2'd2);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL midreset_mask got=%08h exp=00000000", readdata); end
    bus_read(2'd3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL midreset_cap got=%08h exp=00000000", readdata); end
  endtask

  initial begin
    test_reset();
    test_edge_capture();
    test_clear();
    test_set_wins();
    test_falling();
    test_reserved();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
